// File: rtl/reg_dump_streamer_if.sv
// Stream bus carrying register-dump words from reg_dump_streamer to a consumer.
// The master drives the word and its qualifiers; the slave returns tx_ready.
interface reg_dump_streamer_if;
   logic [15:0] tx_data;
   logic [3:0]  tx_tag;
   logic        tx_last;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output tx_data,
      output tx_tag,
      output tx_last,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_tag,
      input  tx_last,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: on a snap request, freezes the PC and a bank of NREGS
// 16-bit registers into a shadow copy, then streams them out one word per
// accepted handshake. Snap requests that arrive mid-frame are counted in a
// saturating drop counter.
// Optional feature macro DUMP_PC_HEADER_EN: when defined, each frame starts
// with a tag-0 PC header word; when undefined the frame is registers only.
module reg_dump_streamer #(
   parameter int NREGS  = 8,
   parameter int DROP_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  snap,
   input  logic [15:0]           pc_in,
   input  logic [16*NREGS-1:0]   regbank_in,
   reg_dump_streamer_if.master   tx,
   output logic                  busy,
   output logic [DROP_W-1:0]     drop_cnt
);

   localparam int IDX_W = $clog2(NREGS + 1);
   localparam int SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS);
`ifdef DUMP_PC_HEADER_EN
   localparam logic [IDX_W-1:0] FIRST_IDX = '0;
`else
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`endif

   typedef enum logic {IDLE, SEND} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;          // word index == tag of current word
   logic [15:0]        regs_q [NREGS];
   logic [15:0]        regs_d [NREGS];
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic [SEL_W-1:0]   reg_sel;

`ifdef DUMP_PC_HEADER_EN
   logic [15:0]        pc_q, pc_d;
`else
   logic               unused_pc;
   assign unused_pc = ^pc_in;
`endif

   // Next-state: capture on snap in IDLE, walk the index in SEND, count drops.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      drop_d  = drop_q;
`ifdef DUMP_PC_HEADER_EN
      pc_d    = pc_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (snap) begin
               state_d = SEND;
               idx_d   = FIRST_IDX;
               for (int k = 0; k < NREGS; k++) begin
                  regs_d[k] = regbank_in[16*k +: 16];
               end
`ifdef DUMP_PC_HEADER_EN
               pc_d    = pc_in;
`endif
            end
         end
         SEND: begin
            // Any snap while a frame is out, including on the last transfer, is dropped.
            if (snap && (drop_q != '1)) begin
               drop_d = drop_q + 1'b1;
            end
            if (tx.tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and shadow registers; reset clears everything, aborting any frame.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         drop_q  <= '0;
         // NOTE: the shadow bank is deliberately reset; its contents must read as zero after reset.
         regs_q  <= '{default: '0};
`ifdef DUMP_PC_HEADER_EN
         pc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
         regs_q  <= regs_d;
`ifdef DUMP_PC_HEADER_EN
         pc_q    <= pc_d;
`endif
      end
   end

   // Register select: tag K+1 carries rK.
   assign reg_sel = SEL_W'(idx_q - 1'b1);

   // Stream outputs come straight from flops, so they hold while stalled and read zero when idle.
   always_comb begin
      tx.tx_valid = (state_q == SEND);
      tx.tx_data  = '0;
      tx.tx_tag   = '0;
      tx.tx_last  = 1'b0;
      if (state_q == SEND) begin
         tx.tx_tag  = 4'(idx_q);
         tx.tx_last = (idx_q == LAST_IDX);
`ifdef DUMP_PC_HEADER_EN
         if (idx_q == '0) begin
            tx.tx_data = pc_q;
         end else begin
            tx.tx_data = regs_q[reg_sel];
         end
`else
         tx.tx_data = regs_q[reg_sel];
`endif
      end
   end

   assign busy     = (state_q == SEND);
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer. A queue-based model holds the
// words every captured frame must still deliver; a compare process checks the
// DUT against it on each falling edge. Directed scenarios pin the model with
// literal expectations, then a randomized phase exercises snap/ready mixes.
module tb_reg_dump_streamer;

   localparam int NREGS    = 8;
   localparam int DROP_W   = 8;
   localparam int DROP_MAX = (1 << DROP_W) - 1;
`ifdef DUMP_PC_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int FRAME_LEN = NREGS + HDR;
   localparam int FIRST_TAG = 1 - HDR;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  tag;
      logic        last;
   } word_t;

   logic                 clk;
   logic                 rst;
   logic                 snap;
   logic [15:0]          pc_in;
   logic [16*NREGS-1:0]  regbank_in;
   logic                 busy;
   logic [DROP_W-1:0]    drop_cnt;

   reg_dump_streamer_if bus ();

   reg_dump_streamer #(.NREGS(NREGS), .DROP_W(DROP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .snap       (snap),
      .pc_in      (pc_in),
      .regbank_in (regbank_in),
      .tx         (bus.master),
      .busy       (busy),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_err = 0;
   word_t exp_q[$];
   int    exp_drop;
   word_t log_q[$];
   int    stall_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a frame is a list of words pushed on capture, popped on acceptance.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         exp_drop = 0;
      end else begin
         bit was_busy;
         was_busy = (exp_q.size() != 0);
         if (was_busy && bus.tx_ready) void'(exp_q.pop_front());
         if (snap) begin
            if (was_busy) begin
               if (exp_drop < DROP_MAX) exp_drop++;
            end else begin
               if (HDR == 1) exp_q.push_back('{data: pc_in, tag: 4'd0, last: 1'b0});
               for (int k = 0; k < NREGS; k++) begin
                  exp_q.push_back('{data: regbank_in[16*k +: 16], tag: 4'(k + 1),
                                    last: (k == NREGS - 1)});
               end
            end
         end
      end
   end

   // Compare process plus a log of accepted words for the directed checks.
   always @(negedge clk) begin
      word_t ex;
      ex = '0;
      if (exp_q.size() != 0) ex = exp_q[0];
      check("tx_valid", bus.tx_valid, exp_q.size() != 0);
      check("busy",     busy,         exp_q.size() != 0);
      check("tx_data",  bus.tx_data,  ex.data);
      check("tx_tag",   bus.tx_tag,   ex.tag);
      check("tx_last",  bus.tx_last,  ex.last);
      check("drop_cnt", drop_cnt,     exp_drop);
      if (bus.tx_valid && bus.tx_ready) log_q.push_back({bus.tx_data, bus.tx_tag, bus.tx_last});
      if (bus.tx_valid && bus.tx_tag == 4'd3) stall_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_regs(input int base);
      for (int k = 0; k < NREGS; k++) regbank_in[16*k +: 16] = 16'(base + k);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", busy, 0);
   endtask

   // Checks the logged frame against hand-computed values: pc 5, r0..r7 = 10..17.
   task automatic check_basic_frame(input string name);
      check({name, "_len"}, log_q.size(), FRAME_LEN);
      for (int i = 0; i < FRAME_LEN && i < log_q.size(); i++) begin
         if (HDR == 1 && i == 0) begin
            check({name, "_hdr_data"}, log_q[i].data, 5);
            check({name, "_hdr_tag"},  log_q[i].tag,  0);
            check({name, "_hdr_last"}, log_q[i].last, 0);
         end else begin
            check({name, "_data"}, log_q[i].data, 10 + i - HDR);
            check({name, "_tag"},  log_q[i].tag,  i - HDR + 1);
            check({name, "_last"}, log_q[i].last, (i == FRAME_LEN - 1));
         end
      end
   endtask

   initial begin
      int n;
      rst          = 1'b0;
      snap         = 1'b0;
      pc_in        = '0;
      regbank_in   = '0;
      bus.tx_ready = 1'b1;
      repeat (3) tick();
      check("reset_valid", bus.tx_valid, 0);
      check("reset_data",  bus.tx_data,  0);
      check("reset_drop",  drop_cnt,     0);
      rst = 1'b1;
      tick();

      // Basic frame with tx_ready held high.
      pc_in = 16'd5;
      set_regs(10);
      log_q.delete();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      check("first_busy", busy, 1);
      check("first_tag",  bus.tx_tag, FIRST_TAG);
      wait_idle(50);
      check_basic_frame("basic");
      check("basic_valid_after", bus.tx_valid, 0);

      // Stall for 3 cycles while the tag-3 word is presented.
      log_q.delete();
      stall_seen = 0;
      snap = 1'b1;
      tick();
      snap = 1'b0;
      n = 0;
      while (!(bus.tx_valid && bus.tx_tag == 4'd3) && n < 20) begin
         tick();
         n++;
      end
      check("stall_reach_tag3", bus.tx_tag, 3);
      check("stall_data", bus.tx_data, 12);
      bus.tx_ready = 1'b0;
      repeat (3) tick();
      bus.tx_ready = 1'b1;
      wait_idle(50);
      check("stall_hold_cycles", stall_seen, 4);
      check_basic_frame("stall");

      // Inputs change right after capture; the shadow must not follow.
      log_q.delete();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      regbank_in = '1;
      pc_in = 16'hFFFF;
      wait_idle(50);
      pc_in = 16'd5;
      set_regs(10);
      check_basic_frame("shadow");

      // snap held through a whole frame: one frame, one drop per SEND cycle.
      log_q.delete();
      snap = 1'b1;
      tick();
      wait_idle(50);
      snap = 1'b0;
      check("held_frames", log_q.size(), FRAME_LEN);
      check("held_drops", drop_cnt, FRAME_LEN);

      // 300 further busy snaps: the counter saturates.
      bus.tx_ready = 1'b0;
      snap = 1'b1;
      tick();
      repeat (300) tick();
      check("drop_saturate", drop_cnt, 255);
      snap = 1'b0;
      bus.tx_ready = 1'b1;
      wait_idle(50);

      // Reset during tag 4 aborts the frame; a new snap restarts from the first tag.
      snap = 1'b1;
      tick();
      snap = 1'b0;
      n = 0;
      while (bus.tx_tag != 4'd4 && n < 20) begin
         tick();
         n++;
      end
      check("abort_reach_tag4", bus.tx_tag, 4);
      rst = 1'b0;
      #1;
      check("abort_valid", bus.tx_valid, 0);
      check("abort_tag",   bus.tx_tag,   0);
      check("abort_data",  bus.tx_data,  0);
      check("abort_busy",  busy,         0);
      check("abort_drop",  drop_cnt,     0);
      repeat (2) tick();
      rst = 1'b1;
      log_q.delete();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      wait_idle(50);
      check_basic_frame("restart");

      // Randomized snap/ready/input activity against the model.
      for (int c = 0; c < 1500; c++) begin
         snap         = ($urandom_range(0, 9) == 0);
         bus.tx_ready = ($urandom_range(0, 3) != 0);
         pc_in        = 16'($urandom);
         for (int k = 0; k < NREGS; k++) regbank_in[16*k +: 16] = 16'($urandom);
         tick();
      end
      snap = 1'b0;
      bus.tx_ready = 1'b1;
      wait_idle(50);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_dump_streamer.md
REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 Parameter: NREGS, 8, number of 16-bit registers in the snapshot.
REQ-002 Parameter: DROP_W, 8, width of the saturating dropped-request counter.
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: snap  input  1  snapshot request, sampled each rising edge.
REQ-006 Port: pc_in  input  16  program counter value to capture.
REQ-007 Port: regbank_in  input  16*NREGS  register bank; r0 at [15:0], rK at [16K+15:16K].
REQ-008 Port: tx_data  output  16  current stream word.
REQ-009 Port: tx_tag  output  4  word identifier; 0 = PC header, K+1 = register rK.
REQ-010 Port: tx_last  output  1  high with the final word of a frame.
REQ-011 Port: tx_valid  output  1  stream word valid.
REQ-012 Port: tx_ready  input  1  downstream accepts word when high with tx_valid.
REQ-013 Port: busy  output  1  high while a frame is being held or sent.
REQ-014 Port: drop_cnt  output  DROP_W  count of snap requests ignored while busy.

Function
REQ-015 Two states SHALL exist: IDLE and SEND.
REQ-016 In IDLE, snap=1 at a rising edge SHALL capture pc_in and regbank_in into an internal shadow and move to SEND; tx_valid and busy SHALL be high from the next cycle.
REQ-017 The frame SHALL be: header (tag 0, data = captured PC), then r0..r(NREGS-1) with tags 1..NREGS, in order.
REQ-018 A word SHALL transfer at a rising edge where tx_valid=1 and tx_ready=1; the next word SHALL be presented the following cycle with no bubble.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data, tx_tag and tx_last SHALL hold stable.
REQ-020 tx_valid SHALL NOT drop in SEND before the last word transfers.
REQ-021 tx_last SHALL be high only with the rNREGS-1 word (tag NREGS).
REQ-022 On transfer of the last word the block SHALL return to IDLE; tx_valid and busy SHALL be low the next cycle.
REQ-023 Shadow contents SHALL NOT change during SEND regardless of pc_in/regbank_in activity.
REQ-024 snap=1 at any edge in SEND, including the edge of the last transfer, SHALL be ignored and SHALL increment drop_cnt, saturating at all-ones.
REQ-025 Minimum snap-to-snap spacing for no drops: one full frame plus one IDLE cycle.
REQ-026 tx_data/tx_tag/tx_last SHALL be 0 whenever tx_valid=0.

Reset
REQ-027 rst low SHALL immediately force IDLE, tx_valid=0, tx_last=0, tx_data=0, tx_tag=0, busy=0, drop_cnt=0, shadow=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no partial continuation after release.
REQ-029 First snap sampled SHALL be at the first rising edge with rst high.

Configuration
REQ-030 Macro DUMP_PC_HEADER_EN: defined -> frame is NREGS+1 words starting with the tag-0 PC header; undefined -> header omitted, frame is NREGS words starting at tag 1, pc_in unused.

Verification
REQ-031 Reset, snap with pc_in=5, r0..r7=10..17, tx_ready=1 -> 9 consecutive words tags 0..8, data 5,10..17, tx_last only on tag 8, busy low after.
REQ-032 Same snapshot, tx_ready low for 3 cycles on tag 3 -> tag 3 word (data 12) held stable 4 cycles, no word lost or repeated.
REQ-033 Change regbank_in to all 16'hFFFF one cycle after snap -> streamed words still 10..17.
REQ-034 snap held high for whole frame (9 cycles in SEND) -> exactly one frame, drop_cnt=9; 300 further busy snaps -> drop_cnt saturates at 255.
REQ-035 rst low during tag 4 -> outputs zero immediately; after release and new snap, frame restarts at tag 0.
REQ-036 DUMP_PC_HEADER_EN undefined, repeat REQ-031 -> 8 words tags 1..8, data 10..17.
